music_note_sequencer: RTL and testbench

Melody sequencer between the tempo divider and the DDS phase accumulator. It consumes the divider's beat clock as a plain data signal in the `sys_clk` domain. It steps through a score ROM of note/duration entries and drives the DDS with a 32-bit frequency tuning word (FTW) and a note-on flag. It supports start/stop control, an end-of-song marker and optional looping.

---
 rtl/music_pkg.sv | 63 ++++++
 rtl/music_note_sequencer_rom.sv | 29 ++
 rtl/music_note_sequencer.sv | 145 ++++++++++++++
 tb/tb_music_note_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types for the melody sequencer: score entry layout, FSM states and
// the note-code to DDS tuning-word table (100 MHz reference, 32-bit accumulator).
package music_pkg;

  localparam int unsigned NOTE_W  = 5;
  localparam int unsigned DUR_W   = 3;
  localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 5'd10;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } score_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_DONE
  } state_t;

  // Equal temperament, note 1 = C4 ... note 31 = F#6, FTW = round(f * 2^32 / 100e6).
  function automatic logic [31:0] note_to_ftw(input logic [NOTE_W-1:0] note);
    case (note)
      5'd1:    return 32'd11237;
      5'd2:    return 32'd11905;
      5'd3:    return 32'd12613;
      5'd4:    return 32'd13363;
      5'd5:    return 32'd14157;
      5'd6:    return 32'd14999;
      5'd7:    return 32'd15891;
      5'd8:    return 32'd16836;
      5'd9:    return 32'd17837;
      NOTE_A4: return 32'd18898;
      5'd11:   return 32'd20022;
      5'd12:   return 32'd21212;
      5'd13:   return 32'd22473;
      5'd14:   return 32'd23810;
      5'd15:   return 32'd25226;
      5'd16:   return 32'd26726;
      5'd17:   return 32'd28315;
      5'd18:   return 32'd29998;
      5'd19:   return 32'd31782;
      5'd20:   return 32'd33672;
      5'd21:   return 32'd35674;
      5'd22:   return 32'd37796;
      5'd23:   return 32'd40043;
      5'd24:   return 32'd42424;
      5'd25:   return 32'd44947;
      5'd26:   return 32'd47620;
      5'd27:   return 32'd50451;
      5'd28:   return 32'd53451;
      5'd29:   return 32'd56630;
      5'd30:   return 32'd59997;
      5'd31:   return 32'd63565;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/music_note_sequencer_rom.sv
// Synchronous-read score ROM; contents come from the SCORE parameter with
// entry i held in bits [ENTRY_W*i +: ENTRY_W].
module music_score_rom
  import music_pkg::*;
#(
  parameter int unsigned                     ADDR_W = 6,
  parameter logic [(ENTRY_W << ADDR_W)-1:0] SCORE  = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  output score_entry_t      data_o
);

  localparam int unsigned SHIFT = $clog2(ENTRY_W);

  logic [ADDR_W+SHIFT-1:0] base;
  score_entry_t            data_q;

  assign base = {addr_i, SHIFT'(0)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= SCORE[base +: ENTRY_W];
  end

  assign data_o = data_q;

endmodule

// File: rtl/music_note_sequencer.sv
// Melody sequencer: walks the score ROM on beat ticks and drives the DDS
// tuning word and note-on flag, with start/stop, end marker and optional loop.
module music_note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned                     ADDR_W = 6,
  parameter int unsigned                     FTW_W  = 32,
  parameter bit                              LOOP   = 1'b0,
  parameter logic [(ENTRY_W << ADDR_W)-1:0] SCORE  = '0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              beat_in,
  input  logic              play,
  output logic [FTW_W-1:0]  ftw,
  output logic              note_on,
  output logic [ADDR_W-1:0] note_idx,
  output logic              busy,
  output logic              song_done
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  note_idx_q, note_idx_d;
  logic [DUR_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic               note_on_q, note_on_d;
  logic               song_done_q, song_done_d;
  logic               beat_s1_q, beat_s2_q, beat_prev_q, tick_q;
  score_entry_t       entry;

  music_score_rom #(
    .ADDR_W (ADDR_W),
    .SCORE  (SCORE)
  ) u_rom (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .addr_i (addr_q),
    .data_o (entry)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      beat_s1_q   <= 1'b0;
      beat_s2_q   <= 1'b0;
      beat_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      beat_s1_q   <= beat_in;
      beat_s2_q   <= beat_s1_q;
      beat_prev_q <= beat_s2_q;
      tick_q      <= beat_s2_q & ~beat_prev_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      note_idx_q  <= '0;
      beat_cnt_q  <= '0;
      ftw_q       <= '0;
      note_on_q   <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      note_idx_q  <= note_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      ftw_q       <= ftw_d;
      note_on_q   <= note_on_d;
      song_done_q <= song_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    note_idx_d  = note_idx_q;
    beat_cnt_d  = beat_cnt_q;
    ftw_d       = ftw_q;
    note_on_d   = note_on_q;
    song_done_d = 1'b0;
    if (!play) begin
      state_d    = ST_IDLE;
      addr_d     = '0;
      note_idx_d = '0;
      beat_cnt_d = '0;
      ftw_d      = '0;
      note_on_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_d    = '0;
          ftw_d     = '0;
          note_on_d = 1'b0;
          state_d   = ST_FETCH;
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          // note_idx follows the end marker too, so a looping score shows its last address.
          note_idx_d = addr_q;
          if (entry.dur == '0) begin
            song_done_d = 1'b1;
            ftw_d       = '0;
            note_on_d   = 1'b0;
            if (LOOP) begin
              addr_d  = '0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            ftw_d      = FTW_W'(note_to_ftw(entry.note));
            note_on_d  = (entry.note != NOTE_REST);
            beat_cnt_d = entry.dur;
            state_d    = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_q) begin
            if (beat_cnt_q == DUR_W'(1)) begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_FETCH;
            end else begin
              beat_cnt_d = beat_cnt_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          ftw_d     = '0;
          note_on_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ftw       = ftw_q;
  assign note_on   = note_on_q;
  assign note_idx  = note_idx_q;
  assign song_done = song_done_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_PLAY);

endmodule

// File: tb/tb_music_note_sequencer.sv
// Directed bench: four sequencer instances (basic, rest, loop, 2-bit wrap)
// share clock, reset, beat and play; expectations flow through a scoreboard queue.
module tb_music_note_sequencer;

  localparam logic [511:0] SC_BASIC = 512'h00_52;
  localparam logic [511:0] SC_REST  = 512'h00_51_01;
  localparam logic [511:0] SC_LOOP  = 512'h00_51;
  localparam logic [31:0]  SC_WRAP  = 32'h01_51_01_51;
  localparam logic [31:0]  A4       = 32'd18898;

  logic clk = 1'b0;
  logic rst, beat, play;

  logic [31:0] b_ftw, r_ftw, l_ftw, w_ftw;
  logic [5:0]  b_idx, r_idx, l_idx;
  logic [1:0]  w_idx;
  logic        b_on, r_on, l_on, w_on;
  logic        b_busy, r_busy, l_busy, w_busy;
  logic        b_done, r_done, l_done, w_done;

  always #5 clk = ~clk;

  music_note_sequencer #(.ADDR_W(6), .FTW_W(32), .LOOP(1'b0), .SCORE(SC_BASIC)) u_basic (
    .sys_clk(clk), .rst(rst), .beat_in(beat), .play(play), .ftw(b_ftw),
    .note_on(b_on), .note_idx(b_idx), .busy(b_busy), .song_done(b_done));
  music_note_sequencer #(.ADDR_W(6), .FTW_W(32), .LOOP(1'b0), .SCORE(SC_REST)) u_rest (
    .sys_clk(clk), .rst(rst), .beat_in(beat), .play(play), .ftw(r_ftw),
    .note_on(r_on), .note_idx(r_idx), .busy(r_busy), .song_done(r_done));
  music_note_sequencer #(.ADDR_W(6), .FTW_W(32), .LOOP(1'b1), .SCORE(SC_LOOP)) u_loop (
    .sys_clk(clk), .rst(rst), .beat_in(beat), .play(play), .ftw(l_ftw),
    .note_on(l_on), .note_idx(l_idx), .busy(l_busy), .song_done(l_done));
  music_note_sequencer #(.ADDR_W(2), .FTW_W(32), .LOOP(1'b0), .SCORE(SC_WRAP)) u_wrap (
    .sys_clk(clk), .rst(rst), .beat_in(beat), .play(play), .ftw(w_ftw),
    .note_on(w_on), .note_idx(w_idx), .busy(w_busy), .song_done(w_done));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned b_dones = 0, r_dones = 0, l_dones = 0, w_dones = 0;

  always @(negedge clk) begin
    if (b_done) b_dones++;
    if (r_done) r_dones++;
    if (l_done) l_dones++;
    if (w_done) w_dones++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %0d with no expected value queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  // beat_in high for 3 edges then low for 3: the tick reaches the FSM on
  // the 4th edge and a following LOAD result is visible when this returns.
  task automatic beat_pulse();
    beat = 1'b1;
    step(3);
    beat = 1'b0;
    step(3);
  endtask

  initial begin
    rst  = 1'b1;
    play = 1'b0;
    beat = 1'b0;

    // reset state
    expect_v("rst_ftw", 0); expect_v("rst_on", 0); expect_v("rst_busy", 0);
    expect_v("rst_idx", 0); expect_v("rst_done", 0);
    step(2);
    observe(b_ftw); observe(32'(b_on)); observe(32'(b_busy));
    observe(32'(b_idx)); observe(32'(b_done));
    rst = 1'b0;
    step(2);

    // start latency: ftw appears on the third edge after play rises
    expect_v("start_ftw_early", 0);
    play = 1'b1;
    step(2);
    observe(b_ftw);
    expect_v("start_b_ftw", A4); expect_v("start_b_on", 1); expect_v("start_b_busy", 1);
    expect_v("start_r_ftw", 0); expect_v("start_r_on", 0); expect_v("start_r_busy", 1);
    expect_v("start_l_ftw", A4); expect_v("start_w_ftw", A4);
    step(1);
    observe(b_ftw); observe(32'(b_on)); observe(32'(b_busy));
    observe(r_ftw); observe(32'(r_on)); observe(32'(r_busy));
    observe(l_ftw); observe(w_ftw);

    // beat 1
    expect_v("b1_b_ftw_hold", A4); expect_v("b1_b_busy", 1);
    expect_v("b1_r_ftw", A4); expect_v("b1_r_on", 1); expect_v("b1_r_idx", 1);
    expect_v("b1_l_done", 1); expect_v("b1_l_ftw", 0); expect_v("b1_l_idx", 1);
    expect_v("b1_w_idx", 1); expect_v("b1_w_ftw", 0);
    beat_pulse();
    observe(b_ftw); observe(32'(b_busy));
    observe(r_ftw); observe(32'(r_on)); observe(32'(r_idx));
    observe(32'(l_done)); observe(l_ftw); observe(32'(l_idx));
    observe(32'(w_idx)); observe(w_ftw);
    expect_v("b1_l_done_one_cycle", 0);
    step(1);
    observe(32'(l_done));
    expect_v("b1_l_ftw_reload", A4); expect_v("b1_l_idx_back", 0);
    step(1);
    observe(l_ftw); observe(32'(l_idx));

    // beat 2: basic and rest reach their end markers
    expect_v("b2_b_done", 1); expect_v("b2_b_ftw", 0); expect_v("b2_b_on", 0);
    expect_v("b2_b_busy", 0); expect_v("b2_b_idx", 1);
    expect_v("b2_r_done", 1); expect_v("b2_r_ftw", 0);
    expect_v("b2_w_idx", 2); expect_v("b2_w_ftw", A4); expect_v("b2_l_done", 1);
    beat_pulse();
    observe(32'(b_done)); observe(b_ftw); observe(32'(b_on));
    observe(32'(b_busy)); observe(32'(b_idx));
    observe(32'(r_done)); observe(r_ftw);
    observe(32'(w_idx)); observe(w_ftw); observe(32'(l_done));
    expect_v("b2_b_done_clear", 0);
    step(2);
    observe(32'(b_done));

    // beats 3 and 4: wrap from address 3 back to 0
    for (int i = 0; i < 2; i++) begin
      expect_v("wrap_idx", (i == 0) ? 32'd3 : 32'd0);
      beat_pulse();
      observe(32'(w_idx));
      step(2);
    end
    expect_v("wrap_ftw", A4); expect_v("done_b_busy", 0); expect_v("done_b_ftw", 0);
    expect_v("cnt_b_done", 1); expect_v("cnt_r_done", 1);
    expect_v("cnt_l_done", 4); expect_v("cnt_w_done", 0);
    observe(w_ftw); observe(32'(b_busy)); observe(b_ftw);
    observe(b_dones); observe(r_dones); observe(l_dones); observe(w_dones);

    // stop in the same cycle as a tick: stop wins, no FETCH
    beat = 1'b1;
    step(3);
    play = 1'b0;
    expect_v("stop_l_busy", 0); expect_v("stop_l_ftw", 0); expect_v("stop_l_on", 0);
    expect_v("stop_l_idx", 0); expect_v("stop_w_busy", 0); expect_v("stop_w_ftw", 0);
    step(1);
    observe(32'(l_busy)); observe(l_ftw); observe(32'(l_on));
    observe(32'(l_idx)); observe(32'(w_busy)); observe(w_ftw);
    beat = 1'b0;
    expect_v("stop_l_busy_later", 0); expect_v("stop_l_dones", 4);
    step(4);
    observe(32'(l_busy)); observe(l_dones);

    // restart from DONE via IDLE
    play = 1'b1;
    expect_v("restart_b_ftw", A4);
    step(3);
    observe(b_ftw);
    expect_v("restart_r_idx", 1); expect_v("restart_r_on", 1);
    beat_pulse();
    observe(32'(r_idx)); observe(32'(r_on));

    // asynchronous reset mid-note
    expect_v("arst_r_ftw", 0); expect_v("arst_r_on", 0); expect_v("arst_r_busy", 0);
    expect_v("arst_r_idx", 0); expect_v("arst_w_idx", 0); expect_v("arst_b_busy", 0);
    rst = 1'b1;
    #2;
    observe(r_ftw); observe(32'(r_on)); observe(32'(r_busy));
    observe(32'(r_idx)); observe(32'(w_idx)); observe(32'(b_busy));
    step(2);
    rst = 1'b0;
    expect_v("post_rst_fetch_busy", 1);
    step(1);
    observe(32'(b_busy));
    play = 1'b0;
    step(2);

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL sb_leftover: observed %0d queued expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
